// File: rtl/phys_reg_free_list.sv
// Physical register free list for the rename stage.
// Circular tag FIFO with one branch checkpoint of the allocation pointer.
module phys_reg_free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = $clog2(PHYS_REGS),
  parameter int DEPTH     = PHYS_REGS - ARCH_REGS,
  parameter int PTR_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             rel_valid,
  input  logic [TAG_W-1:0] rel_tag,
  input  logic             ckpt_take,
  input  logic             recover,
  output logic [PTR_W-1:0] free_count,
  output logic             overflow
);

  localparam int IDX_W = PTR_W - 1;

  logic [TAG_W-1:0] entry_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] ckpt_q, ckpt_d;
  logic [PTR_W-1:0] adv_head;
  logic             ovf_q, ovf_d;
  logic             empty, full;
  logic             do_alloc, do_rel;

  always_comb begin
    empty    = (head_q == tail_q);
    full     = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0])
            && (head_q[PTR_W-1] != tail_q[PTR_W-1]);
    do_alloc = alloc_req && !empty && !recover;
    do_rel   = rel_valid && !full;
    adv_head = head_q + PTR_W'(do_alloc);
    // Recovery wins over this cycle's allocate and checkpoint.
    head_d   = recover ? ckpt_q : adv_head;
    ckpt_d   = (ckpt_take && !recover) ? adv_head : ckpt_q;
    tail_d   = tail_q + PTR_W'(do_rel);
    ovf_d    = ovf_q | (rel_valid & full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= PTR_W'(DEPTH);
      ckpt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ckpt_q <= ckpt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        entry_q[i] <= TAG_W'(ARCH_REGS + i);
    end else if (do_rel) begin
      entry_q[tail_q[IDX_W-1:0]] <= rel_tag;
    end
  end

  assign alloc_valid = !empty;
  assign alloc_tag   = entry_q[head_q[IDX_W-1:0]];
  assign free_count  = tail_q - head_q;
  assign overflow    = ovf_q;

endmodule
